// File: rtl/uart_pkg.sv
// Shared UART definitions: TX state encoding, parity mode codes and the
// baud divider rounding used by both the TX and RX cores.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // Clock cycles per bit, rounded to the nearest integer.
    function automatic int calc_baud_div(input int clk_freq, input int baud_rate);
        return (clk_freq + baud_rate / 2) / baud_rate;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-time generator: counts 0..BAUD_DIV-1 while enabled and strobes bit_end_o
// on the last cycle of each bit. A clear forces the count back to zero.
module uart_baud_gen #(
    parameter int BAUD_DIV = 434
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic clr_i,
    output logic bit_end_o
);

    localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_end_o = en_i && !clr_i && (cnt_q == LAST);

endmodule

// File: rtl/uart_tx_core.sv
// Byte-level UART transmitter: start bit, 8 data bits LSB first, optional
// parity and 1 or 2 stop bits, with registered line, busy and done outputs.
module uart_tx_core
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 115200,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic       SYS_CLK,
    input  logic       RST_N,
    input  logic [7:0] data_in,
    input  logic       tx_req,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       uart_txd,
    output logic [2:0] dbg_state_o
);

    localparam int   BAUD_DIV  = calc_baud_div(CLK_FREQ, BAUD_RATE);
    localparam logic PAR_EN    = (PARITY != PAR_NONE);
    localparam logic PAR_INV   = (PARITY == PAR_ODD);
    localparam logic STOP_LAST = (STOP_BITS == 2);

    if (BAUD_DIV < 2) begin : g_bad_baud
        $error("uart_tx_core: BAUD_DIV must be at least 2");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_tx_core: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_tx_core: STOP_BITS must be 1 or 2");
    end

    tx_state_e  state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic       par_q, par_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic       stop_cnt_q, stop_cnt_d;
    logic       txd_q, txd_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       bit_end;

    // The counter is held cleared in IDLE so every frame starts on a fresh bit.
    uart_baud_gen #(
        .BAUD_DIV(BAUD_DIV)
    ) u_baud (
        .clk_i    (SYS_CLK),
        .rst_ni   (RST_N),
        .en_i     (state_q != ST_IDLE),
        .clr_i    (state_q == ST_IDLE),
        .bit_end_o(bit_end)
    );

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        par_d      = par_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        txd_d      = txd_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                txd_d  = 1'b1;
                busy_d = 1'b0;
                if (tx_req) begin
                    state_d    = ST_START;
                    shift_d    = data_in;
                    par_d      = (^data_in) ^ PAR_INV;
                    bit_cnt_d  = '0;
                    stop_cnt_d = 1'b0;
                    txd_d      = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = '0;
                    txd_d     = shift_q[0];
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_cnt_q == 3'd7) begin
                        if (PAR_EN) begin
                            state_d = ST_PARITY;
                            txd_d   = par_q;
                        end else begin
                            state_d    = ST_STOP;
                            stop_cnt_d = 1'b0;
                            txd_d      = 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        txd_d     = shift_q[1];
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    state_d    = ST_STOP;
                    stop_cnt_d = 1'b0;
                    txd_d      = 1'b1;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    if (stop_cnt_q == STOP_LAST) begin
                        // Returning to IDLE forces at least one non-busy cycle.
                        state_d = ST_IDLE;
                        txd_d   = 1'b1;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        stop_cnt_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                txd_d   = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge SYS_CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            par_q      <= 1'b0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            txd_q      <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            txd_q      <= txd_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign uart_txd    = txd_q;
    assign tx_busy     = busy_q;
    assign tx_done     = done_q;
    assign dbg_state_o = state_q;

endmodule

// File: doc/uart_tx_core.md
Name: uart_tx_core

Overview:
- Byte-level UART serialiser sitting directly downstream of the UART control stage.
- Accepts an 8-bit byte under a level request (tx_req) and reports frame-in-progress on tx_busy.
- Drives the asynchronous serial line: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
- Bit timing comes from an internal baud divider derived from the system clock.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- BAUD_RATE, 115200, serial bit rate in bits/s.
- PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, number of stop bits: 1 or 2.
- BAUD_DIV (derived localparam), (CLK_FREQ + BAUD_RATE/2) / BAUD_RATE, clock cycles per bit. Integer division; 434 at defaults. Elaboration error if BAUD_DIV < 2.

Ports:
- SYS_CLK  input  1  system clock; all logic on the rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- data_in  input  8  byte to send; sampled only at frame start.
- tx_req  input  1  level request; a frame starts whenever it is high while the core is idle.
- tx_busy  output  1  high from the first start-bit cycle through the last stop-bit cycle.
- tx_done  output  1  one-cycle pulse on the first idle cycle after a frame.
- uart_txd  output  1  serial line; idles high.

Behaviour:
- Clock and reset: one clock, SYS_CLK. Reset is asynchronous and active-low on RST_N.
- Reset values: uart_txd = 1, tx_busy = 0, tx_done = 0, state = IDLE, baud counter = 0, bit counter = 0, shift register = 0.
- States: IDLE, START, DATA, PARITY, STOP. All outputs are registered.
- IDLE:
  - uart_txd = 1, tx_busy = 0.
  - If tx_req = 1 at a clock edge: latch data_in into the shift register, compute the parity bit from the latched byte, clear the baud counter, go to START.
- Latency: uart_txd falls and tx_busy rises on the clock edge that samples tx_req high, so both are visible in the following cycle.
- Bit timing:
  - Each bit holds uart_txd for exactly BAUD_DIV cycles.
  - The baud counter counts 0..BAUD_DIV-1; a bit ends when it reaches BAUD_DIV-1, and the counter then wraps to 0.
- START: uart_txd = 0 for one bit time, then DATA.
- DATA:
  - uart_txd = shift register bit 0; shift right at each bit end.
  - A 3-bit counter counts 8 bits. After bit 7 go to PARITY if PARITY != 0, else STOP.
- PARITY:
  - Even mode: uart_txd = XOR of the 8 data bits.
  - Odd mode: uart_txd = inverse of that XOR.
  - One bit time, then STOP.
- STOP: uart_txd = 1 for STOP_BITS bit times, then IDLE.
- tx_busy:
  - High in every state other than IDLE.
  - Busy time per frame is (1 + 8 + P + STOP_BITS) * BAUD_DIV cycles, where P = 1 if parity is enabled, else 0.
- tx_done: pulses high in the first IDLE cycle after STOP completes.
- Back-to-back frames:
  - Every frame is followed by at least one IDLE cycle with tx_busy = 0, so the upstream stage always sees busy fall.
  - If tx_req is still high in that cycle, the next frame starts immediately with the then-current data_in.
  - Minimum frame-to-frame period is busy time + 1 cycle.
- Mid-frame input changes:
  - tx_req falling mid-frame does not abort the frame.
  - Changes on data_in mid-frame have no effect.
- Reset mid-frame: uart_txd goes high and tx_busy goes low immediately (asynchronously). The partial frame is discarded and no tx_done is generated.
- Simultaneous end of frame and tx_req high: the mandatory IDLE cycle is honoured first; the new frame starts on the following edge.

Decomposition:
- Shared package uart_pkg holds:
  - the state encoding localparams (IDLE/START/DATA/PARITY/STOP);
  - the parity mode codes (PAR_NONE = 0, PAR_ODD = 1, PAR_EVEN = 2);
  - the BAUD_DIV rounding function, shared with the future RX core.
- One natural sub-module, uart_baud_gen:
  - parameterised by BAUD_DIV, with enable and clear inputs;
  - outputs a one-cycle bit_end strobe;
  - reused by the RX side.
- Shift register, parity logic and FSM stay in uart_tx_core.

Test Plan:
- Common bench parameters: CLK_FREQ = 1_600_000 and BAUD_RATE = 100_000, giving BAUD_DIV = 16.
- Reset: hold RST_N low with tx_req = 1 -> uart_txd = 1, tx_busy = 0, tx_done = 0 throughout. After release, a frame starts on the first edge.
- Single byte: data_in = 0xA5, tx_req pulsed for 1 cycle:
  - uart_txd sequence 0,1,0,1,0,0,1,0,1,1, each bit exactly 16 cycles;
  - tx_busy high for exactly 160 cycles;
  - one tx_done pulse.
- Upstream two-byte sequence: data_in = 0x01 with tx_req = 1; switch data_in to 0xFE once tx_busy rises; drop tx_req once tx_busy rises for the second frame:
  - frame 1 carries 0x01 and frame 2 carries 0xFE;
  - tx_busy is low for exactly 1 cycle between frames;
  - no third frame.
- Parity and stop bits: PARITY = 2 with data 0x07 -> parity bit 1. PARITY = 1 with data 0x07 -> parity bit 0. PARITY = 2 with STOP_BITS = 2 -> tx_busy high for 192 cycles.
- Reset mid-frame: assert RST_N low at busy cycle 50 -> uart_txd = 1 and tx_busy = 0 within the same cycle, no tx_done. After release with tx_req = 0 the core stays idle.
- Input glitches mid-frame: toggle data_in every cycle and deassert tx_req during a 0x3C frame -> the line still carries 0x3C and the frame completes fully.
